pipe_regfile: RTL

Parametrised successor to the pipeline's general-purpose register file, sitting between ID (reads) and WB (writes).
- NUM_RPORTS combinational read ports.
- WB→ID write bypass.
- Per-register pending-write scoreboard that flags RAW hazards to the hazard unit.
- Post-reset sequential clear FSM, so the array needs no asynchronous reset.

---
 rtl/pipe_regfile_pkg.sv | 17 +
 rtl/pipe_regfile_if.sv | 40 ++++
 rtl/pipe_regfile_scoreboard.sv | 70 +++++++
 rtl/pipe_regfile.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_regfile_pkg.sv
// pipe_regfile_pkg: shared defaults and FSM state encoding for the
// pipelined general-purpose register file (pipe_regfile) and its
// scoreboard sub-module (regfile_scoreboard).
package pipe_regfile_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_NUM_RPORTS = 2;
  localparam int RF_PEND_W     = 2;

  // INIT sweeps zeros into the array after reset; RUN is normal operation.
  typedef enum logic {
    RF_ST_INIT = 1'b0,
    RF_ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/pipe_regfile_if.sv
// pipe_regfile_if: bundle between the pipeline (ID/WB/hazard unit) and
// the register file.
//   master : pipeline side, drives write/read/issue requests
//   slave  : register file side, returns read data, hazards, issue_ready
// Signals:
//   we/waddr/wdata          WB write port
//   raddr/rdata/hazard      packed read ports, port i at slice i
//   issue_valid/issue_rd    ID issue of an instruction writing issue_rd
//   issue_ready             issue_rd can accept another pending write
//   init_done               clear sweep finished
interface pipe_regfile_if
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int NUM_RPORTS = RF_NUM_RPORTS
) ();

  logic                         we;
  logic [ADDR_W-1:0]            waddr;
  logic [DATA_W-1:0]            wdata;
  logic [NUM_RPORTS*ADDR_W-1:0] raddr;
  logic [NUM_RPORTS*DATA_W-1:0] rdata;
  logic [NUM_RPORTS-1:0]        hazard;
  logic                         issue_valid;
  logic [ADDR_W-1:0]            issue_rd;
  logic                         issue_ready;
  logic                         init_done;

  modport master (
    output we, waddr, wdata, raddr, issue_valid, issue_rd,
    input  rdata, hazard, issue_ready, init_done
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_valid, issue_rd,
    output rdata, hazard, issue_ready, init_done
  );

endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters.
// An accepted issue to rd increments pend[rd]; a WB write decrements the
// written register's counter (never below zero). Register 0 stays at 0.
// Ports:
//   clk, rst      clock, async active-high reset (clears all counters)
//   run           register file has finished its clear sweep
//   we, waddr     WB write
//   issue_valid   ID issue, issue_rd its destination
//   raddr         packed read addresses
//   issue_ready   issue_rd counter below saturation (and run)
//   rd_pend       raw counter value for each read port, packed
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int NUM_RPORTS = RF_NUM_RPORTS,
  parameter int PEND_W     = RF_PEND_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_rd,
  input  logic [NUM_RPORTS*ADDR_W-1:0] raddr,
  output logic                         issue_ready,
  output logic [NUM_RPORTS*PEND_W-1:0] rd_pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [PEND_W-1:0] pend [DEPTH];
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;

  assign issue_ready = run && ((issue_rd == '0) || (pend[issue_rd] != '1));

  // Register 0 never gets an inc or dec bit, so its counter stays at 0.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    inc_vec[issue_rd] = issue_valid && issue_ready && (issue_rd != '0);
    dec_vec[waddr]    = run && we && (waddr != '0) && (pend[waddr] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   pend[r] <= pend[r] + PEND_W'(1);
          2'b01:   pend[r] <= pend[r] - PEND_W'(1);
          default: pend[r] <= pend[r];
        endcase
      end
    end
  end

  always_comb begin
    rd_pend = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rd_pend[i*PEND_W +: PEND_W] = pend[raddr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: general-purpose register file between ID (reads) and WB
// (writes), with combinational read ports, WB->ID bypass and a pending-
// write scoreboard that raises RAW hazards.
// After reset a sweep writes zero into every entry (2**ADDR_W cycles);
// until it finishes, writes and issues are ignored and outputs read 0.
// Ports:
//   clk, rst   clock, async active-high reset (control state only)
//   rf         pipe_regfile_if.slave bundle (write, read, issue, status)
// Build option REGFILE_BYPASS_EN:
//   defined   -> a same-cycle WB write is forwarded to matching reads and
//                masks the hazard of a register with exactly one pending
//                write
//   undefined -> reads return the array only; any pending write is a hazard
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int NUM_RPORTS = RF_NUM_RPORTS,
  parameter int PEND_W     = RF_PEND_W
) (
  input  logic          clk,
  input  logic          rst,
  pipe_regfile_if.slave rf
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e                    state;
  rf_state_e                    state_nxt;
  logic [ADDR_W-1:0]            sweep_idx;
  logic                         sweep_we;
  logic                         run;
  logic                         wr_en;
  logic [DATA_W-1:0]            mem [DEPTH];
  logic [NUM_RPORTS*PEND_W-1:0] rd_pend;
  logic [NUM_RPORTS*DATA_W-1:0] rdata_c;
  logic [NUM_RPORTS-1:0]        hazard_c;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave INIT once the last entry has been cleared
  always_comb begin
    state_nxt = state;
    case (state)
      RF_ST_INIT: if (&sweep_idx) state_nxt = RF_ST_RUN;
      RF_ST_RUN:  state_nxt = RF_ST_RUN;
      default:    state_nxt = RF_ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    sweep_we = 1'b0;
    run      = 1'b0;
    case (state)
      RF_ST_INIT: sweep_we = 1'b1;
      RF_ST_RUN:  run      = 1'b1;
      default:    sweep_we = 1'b1;
    endcase
  end

  // Sweep index; wraps to 0 on the last entry, unused once in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_idx <= '0;
    end else if (sweep_we) begin
      sweep_idx <= sweep_idx + ADDR_W'(1);
    end
  end

  assign wr_en        = run && rf.we && (rf.waddr != '0);
  assign rf.init_done = run;

  // Array has no reset; the sweep provides the cleared contents
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (wr_en) begin
      mem[rf.waddr] <= rf.wdata;
    end
  end

  regfile_scoreboard #(
    .ADDR_W     (ADDR_W),
    .NUM_RPORTS (NUM_RPORTS),
    .PEND_W     (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .we          (rf.we),
    .waddr       (rf.waddr),
    .issue_valid (rf.issue_valid),
    .issue_rd    (rf.issue_rd),
    .raddr       (rf.raddr),
    .issue_ready (rf.issue_ready),
    .rd_pend     (rd_pend)
  );

  // Read ports and hazard masking; everything is 0 during the sweep
  always_comb begin
    rdata_c  = '0;
    hazard_c = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      if (run && (rf.raddr[i*ADDR_W +: ADDR_W] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (rf.we && (rf.waddr == rf.raddr[i*ADDR_W +: ADDR_W])) begin
          rdata_c[i*DATA_W +: DATA_W] = rf.wdata;
          // The write in flight retires exactly one pending entry
          hazard_c[i] = rd_pend[i*PEND_W +: PEND_W] > PEND_W'(1);
        end else begin
          rdata_c[i*DATA_W +: DATA_W] = mem[rf.raddr[i*ADDR_W +: ADDR_W]];
          hazard_c[i] = rd_pend[i*PEND_W +: PEND_W] != '0;
        end
`else
        rdata_c[i*DATA_W +: DATA_W] = mem[rf.raddr[i*ADDR_W +: ADDR_W]];
        hazard_c[i] = rd_pend[i*PEND_W +: PEND_W] != '0;
`endif
      end
    end
  end

  assign rf.rdata  = rdata_c;
  assign rf.hazard = hazard_c;

endmodule
